biriscv_fetch_redirect: RTL and testbench

//  Front-end redirect controller. It sits between the CSR, execute and decode stages and the

---
 rtl/biriscv_fetch_redirect_pkg.sv | 31 +++
 rtl/biriscv_fetch_redirect_if.sv | 40 ++++
 rtl/biriscv_fetch_redirect_prio.sv | 47 ++++
 rtl/biriscv_fetch_redirect.sv | 167 ++++++++++++++++
 tb/tb_biriscv_fetch_redirect.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/biriscv_fetch_redirect_pkg.sv
// Shared definitions for the fetch redirect controller: privilege levels,
// FSM state encodings and the redirect source enumeration.
package biriscv_fetch_redirect_pkg;

  typedef enum logic [1:0] {
    PRIV_USER    = 2'd0,
    PRIV_SUPER   = 2'd1,
    PRIV_MACHINE = 2'd3
  } priv_e;

  typedef enum logic [1:0] {
    REDIR_IDLE   = 2'd0,
    REDIR_FLUSH  = 2'd1,
    REDIR_WAIT   = 2'd2,
    REDIR_RESUME = 2'd3
  } redir_state_e;

  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_CSR    = 3'd1,
    SRC_EXEC0  = 3'd2,
    SRC_EXEC1  = 3'd3,
    SRC_FENCEI = 3'd4
  } redir_src_e;

  // CSR and execute redirects steer fetch directly; FENCE.I goes through the FSM.
  function automatic logic is_pipe_redirect(input redir_src_e src);
    return (src == SRC_CSR) || (src == SRC_EXEC0) || (src == SRC_EXEC1);
  endfunction

endpackage

// File: rtl/biriscv_fetch_redirect_if.sv
// Bundle of redirect sources (CSR, execute, FENCE.I) and the fetch-side
// redirect/invalidate outputs of the fetch redirect controller.
interface biriscv_fetch_redirect_if;
  logic        csr_redirect_i;
  logic [31:0] csr_pc_i;
  logic [1:0]  csr_priv_i;
  logic        exec0_redirect_i;
  logic [31:0] exec0_pc_i;
  logic        exec1_redirect_i;
  logic [31:0] exec1_pc_i;
  logic        fencei_req_i;
  logic [31:0] fencei_pc_i;
  logic [1:0]  cur_priv_i;
  logic        branch_request_o;
  logic [31:0] branch_pc_o;
  logic [1:0]  branch_priv_o;
  logic        fetch_invalidate_o;
  logic        flush_pipe_o;
  logic        busy_o;
  logic [31:0] stat_redirect_o;
  logic [31:0] stat_fencei_o;

  modport master (
    output csr_redirect_i, csr_pc_i, csr_priv_i,
    output exec0_redirect_i, exec0_pc_i, exec1_redirect_i, exec1_pc_i,
    output fencei_req_i, fencei_pc_i, cur_priv_i,
    input  branch_request_o, branch_pc_o, branch_priv_o,
    input  fetch_invalidate_o, flush_pipe_o, busy_o,
    input  stat_redirect_o, stat_fencei_o
  );

  modport slave (
    input  csr_redirect_i, csr_pc_i, csr_priv_i,
    input  exec0_redirect_i, exec0_pc_i, exec1_redirect_i, exec1_pc_i,
    input  fencei_req_i, fencei_pc_i, cur_priv_i,
    output branch_request_o, branch_pc_o, branch_priv_o,
    output fetch_invalidate_o, flush_pipe_o, busy_o,
    output stat_redirect_o, stat_fencei_o
  );
endinterface

// File: rtl/biriscv_fetch_redirect_prio.sv
// Program-order priority select among redirect sources:
// csr > exec0 (older) > exec1 (younger) > fencei.
module biriscv_redirect_prio
  import biriscv_fetch_redirect_pkg::*;
(
  input  logic        csr_redirect_i,
  input  logic [31:0] csr_pc_i,
  input  logic [1:0]  csr_priv_i,
  input  logic        exec0_redirect_i,
  input  logic [31:0] exec0_pc_i,
  input  logic        exec1_redirect_i,
  input  logic [31:0] exec1_pc_i,
  input  logic        fencei_req_i,
  input  logic [31:0] fencei_pc_i,
  input  logic [1:0]  cur_priv_i,
  output logic        sel_valid_o,
  output logic [31:0] sel_pc_o,
  output logic [1:0]  sel_priv_o,
  output redir_src_e  sel_src_o
);

  always_comb begin
    sel_valid_o = 1'b0;
    sel_pc_o    = 32'b0;
    sel_priv_o  = cur_priv_i;
    sel_src_o   = SRC_NONE;
    if (csr_redirect_i) begin
      sel_valid_o = 1'b1;
      sel_pc_o    = csr_pc_i;
      sel_priv_o  = csr_priv_i;
      sel_src_o   = SRC_CSR;
    end else if (exec0_redirect_i) begin
      sel_valid_o = 1'b1;
      sel_pc_o    = exec0_pc_i;
      sel_src_o   = SRC_EXEC0;
    end else if (exec1_redirect_i) begin
      sel_valid_o = 1'b1;
      sel_pc_o    = exec1_pc_i;
      sel_src_o   = SRC_EXEC1;
    end else if (fencei_req_i) begin
      sel_valid_o = 1'b1;
      sel_pc_o    = fencei_pc_i;
      sel_src_o   = SRC_FENCEI;
    end
  end

endmodule

// File: rtl/biriscv_fetch_redirect.sv
// Front-end redirect controller: arbitrates PC redirects and sequences FENCE.I
// (flush, settle wait, resume). Redirect/FENCE.I counters built only with FETCH_REDIRECT_STATS_EN.
module biriscv_fetch_redirect
  import biriscv_fetch_redirect_pkg::*;
#(
  parameter int FLUSH_WAIT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  biriscv_fetch_redirect_if.slave  bus
);

  localparam int CNT_W = (FLUSH_WAIT > 0) ? $clog2(FLUSH_WAIT + 1) : 1;

  logic        sel_valid;
  logic [31:0] sel_pc;
  logic [1:0]  sel_priv;
  redir_src_e  sel_src;
  logic        pipe_hit;

  redir_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [1:0]  pend_priv_q, pend_priv_d;
  logic        br_req_q, br_req_d;
  logic [31:0] br_pc_q, br_pc_d;
  logic [1:0]  br_priv_q, br_priv_d;
  logic        inval_q, inval_d;

  biriscv_redirect_prio u_prio (
    .csr_redirect_i   (bus.csr_redirect_i),
    .csr_pc_i         (bus.csr_pc_i),
    .csr_priv_i       (bus.csr_priv_i),
    .exec0_redirect_i (bus.exec0_redirect_i),
    .exec0_pc_i       (bus.exec0_pc_i),
    .exec1_redirect_i (bus.exec1_redirect_i),
    .exec1_pc_i       (bus.exec1_pc_i),
    .fencei_req_i     (bus.fencei_req_i),
    .fencei_pc_i      (bus.fencei_pc_i),
    .cur_priv_i       (bus.cur_priv_i),
    .sel_valid_o      (sel_valid),
    .sel_pc_o         (sel_pc),
    .sel_priv_o       (sel_priv),
    .sel_src_o        (sel_src)
  );

  assign pipe_hit = sel_valid && is_pipe_redirect(sel_src);

  // While a FENCE.I is in flight, pipe redirects retarget the pending resume PC
  // instead of pulsing; the pending target is emitted on the edge into RESUME.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_pc_d   = pend_pc_q;
    pend_priv_d = pend_priv_q;
    br_req_d    = 1'b0;
    br_pc_d     = br_pc_q;
    br_priv_d   = br_priv_q;
    inval_d     = 1'b0;

    if (state_q != REDIR_IDLE && state_q != REDIR_RESUME && pipe_hit) begin
      pend_pc_d   = sel_pc;
      pend_priv_d = sel_priv;
    end

    case (state_q)
      REDIR_IDLE: begin
        if (pipe_hit) begin
          br_req_d  = 1'b1;
          br_pc_d   = sel_pc;
          br_priv_d = sel_priv;
        end else if (sel_valid) begin
          pend_pc_d   = sel_pc;
          pend_priv_d = sel_priv;
          inval_d     = 1'b1;
          state_d     = REDIR_FLUSH;
        end
      end
      REDIR_FLUSH: begin
        cnt_d = CNT_W'(FLUSH_WAIT);
        if (FLUSH_WAIT == 0) begin
          state_d   = REDIR_RESUME;
          br_req_d  = 1'b1;
          br_pc_d   = pend_pc_d;
          br_priv_d = pend_priv_d;
        end else begin
          state_d = REDIR_WAIT;
        end
      end
      REDIR_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d   = REDIR_RESUME;
          br_req_d  = 1'b1;
          br_pc_d   = pend_pc_d;
          br_priv_d = pend_priv_d;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      REDIR_RESUME: begin
        state_d = REDIR_IDLE;
        if (pipe_hit) begin
          br_req_d  = 1'b1;
          br_pc_d   = sel_pc;
          br_priv_d = sel_priv;
        end
      end
      default: state_d = REDIR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= REDIR_IDLE;
      cnt_q       <= '0;
      pend_pc_q   <= 32'b0;
      pend_priv_q <= PRIV_MACHINE;
      br_req_q    <= 1'b0;
      br_pc_q     <= 32'b0;
      br_priv_q   <= PRIV_MACHINE;
      inval_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_pc_q   <= pend_pc_d;
      pend_priv_q <= pend_priv_d;
      br_req_q    <= br_req_d;
      br_pc_q     <= br_pc_d;
      br_priv_q   <= br_priv_d;
      inval_q     <= inval_d;
    end
  end

  assign bus.branch_request_o   = br_req_q;
  assign bus.flush_pipe_o       = br_req_q;
  assign bus.branch_pc_o        = br_pc_q;
  assign bus.branch_priv_o      = br_priv_q;
  assign bus.fetch_invalidate_o = inval_q;
  assign bus.busy_o             = (state_q != REDIR_IDLE);

`ifdef FETCH_REDIRECT_STATS_EN
  logic [31:0] stat_redirect_q, stat_redirect_d;
  logic [31:0] stat_fencei_q, stat_fencei_d;

  always_comb begin
    stat_redirect_d = stat_redirect_q + {31'b0, br_req_d};
    stat_fencei_d   = stat_fencei_q + {31'b0, inval_d};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_redirect_q <= 32'b0;
      stat_fencei_q   <= 32'b0;
    end else begin
      stat_redirect_q <= stat_redirect_d;
      stat_fencei_q   <= stat_fencei_d;
    end
  end

  assign bus.stat_redirect_o = stat_redirect_q;
  assign bus.stat_fencei_o   = stat_fencei_q;
`else
  assign bus.stat_redirect_o = 32'b0;
  assign bus.stat_fencei_o   = 32'b0;
`endif

endmodule

// File: tb/tb_biriscv_fetch_redirect.sv
// Scoreboard bench for biriscv_fetch_redirect: directed redirects and FENCE.I
// sequences push timestamped expectations; a negedge monitor pops and compares.
module tb_biriscv_fetch_redirect;

  logic clk;
  logic rst;
  int   cyc;
  int   n_compared;
  int   n_mismatched;

  typedef struct {
    int          at;
    logic [31:0] pc;
    logic [1:0]  priv;
  } br_exp_t;

  br_exp_t exp_br[$];
  int      exp_inv[$];

  biriscv_fetch_redirect_if bus();

  biriscv_fetch_redirect #(.FLUSH_WAIT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushBranch(input int at, input logic [31:0] pc, input logic [1:0] priv);
    br_exp_t e;
    e.at   = at;
    e.pc   = pc;
    e.priv = priv;
    exp_br.push_back(e);
  endtask

  // Drives one cycle of requests starting at the current negedge, then clears them.
  task automatic applyStimulus(input logic csr, input logic [31:0] csr_pc, input logic [1:0] csr_priv,
                               input logic e0, input logic [31:0] e0_pc,
                               input logic e1, input logic [31:0] e1_pc,
                               input logic fi, input logic [31:0] fi_pc);
    if (fi) checkOutput("fencei_issued_while_idle", {31'b0, bus.busy_o}, 32'd0);
    bus.csr_redirect_i   = csr;
    bus.csr_pc_i         = csr_pc;
    bus.csr_priv_i       = csr_priv;
    bus.exec0_redirect_i = e0;
    bus.exec0_pc_i       = e0_pc;
    bus.exec1_redirect_i = e1;
    bus.exec1_pc_i       = e1_pc;
    bus.fencei_req_i     = fi;
    bus.fencei_pc_i      = fi_pc;
    @(negedge clk);
    bus.csr_redirect_i   = 1'b0;
    bus.exec0_redirect_i = 1'b0;
    bus.exec1_redirect_i = 1'b0;
    bus.fencei_req_i     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every redirect or invalidate pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.branch_request_o || bus.flush_pipe_o) begin
        checkOutput("flush_pipe_with_request", {31'b0, bus.flush_pipe_o}, {31'b0, bus.branch_request_o});
        if (bus.branch_request_o) begin
          if (exp_br.size() == 0) begin
            checkOutput("unexpected_branch_pc", bus.branch_pc_o, 32'hFFFF_FFFF);
          end else begin
            br_exp_t e;
            e = exp_br.pop_front();
            checkOutput("branch_cycle", cyc, e.at);
            checkOutput("branch_pc", bus.branch_pc_o, e.pc);
            checkOutput("branch_priv", {30'b0, bus.branch_priv_o}, {30'b0, e.priv});
          end
        end
      end
      if (bus.fetch_invalidate_o) begin
        if (exp_inv.size() == 0) begin
          checkOutput("unexpected_invalidate", 32'd1, 32'd0);
        end else begin
          checkOutput("invalidate_cycle", cyc, exp_inv.pop_front());
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    bus.csr_redirect_i   = 1'b0;
    bus.csr_pc_i         = 32'b0;
    bus.csr_priv_i       = 2'd0;
    bus.exec0_redirect_i = 1'b0;
    bus.exec0_pc_i       = 32'b0;
    bus.exec1_redirect_i = 1'b0;
    bus.exec1_pc_i       = 32'b0;
    bus.fencei_req_i     = 1'b0;
    bus.fencei_pc_i      = 32'b0;
    bus.cur_priv_i       = 2'd1;
    n_compared   = 0;
    n_mismatched = 0;
    idle(3);
    rst = 1'b0;

    checkOutput("reset_branch_request", {31'b0, bus.branch_request_o}, 32'd0);
    checkOutput("reset_branch_pc", bus.branch_pc_o, 32'd0);
    checkOutput("reset_branch_priv", {30'b0, bus.branch_priv_o}, 32'd3);
    checkOutput("reset_invalidate", {31'b0, bus.fetch_invalidate_o}, 32'd0);
    checkOutput("reset_flush_pipe", {31'b0, bus.flush_pipe_o}, 32'd0);
    checkOutput("reset_busy", {31'b0, bus.busy_o}, 32'd0);
    checkOutput("reset_stat_redirect", bus.stat_redirect_o, 32'd0);
    checkOutput("reset_stat_fencei", bus.stat_fencei_o, 32'd0);
    idle(1);

    // Single exec0 mispredict, then the target must hold.
    k = cyc;
    pushBranch(k + 1, 32'h8000_0100, 2'd1);
    applyStimulus(0, 0, 0, 1, 32'h8000_0100, 0, 0, 0, 0);
    idle(1);
    checkOutput("hold_request_low", {31'b0, bus.branch_request_o}, 32'd0);
    checkOutput("hold_branch_pc", bus.branch_pc_o, 32'h8000_0100);
    checkOutput("hold_branch_priv", {30'b0, bus.branch_priv_o}, 32'd1);

    // CSR beats both execute slots.
    k = cyc;
    pushBranch(k + 1, 32'h8000_0004, 2'd3);
    applyStimulus(1, 32'h8000_0004, 2'd3, 1, 32'h1111_0000, 1, 32'h2222_0000, 0, 0);
    idle(2);

    // exec0 beats exec1.
    k = cyc;
    pushBranch(k + 1, 32'h0000_1000, 2'd1);
    applyStimulus(0, 0, 0, 1, 32'h0000_1000, 1, 32'h0000_2000, 0, 0);
    idle(1);

    // exec1 with a same-cycle FENCE.I: the FENCE.I is dropped.
    k = cyc;
    pushBranch(k + 1, 32'h0000_3000, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_3000, 1, 32'h0000_0400);
    checkOutput("fencei_dropped_busy", {31'b0, bus.busy_o}, 32'd0);
    idle(2);

    // Full FENCE.I sequence: invalidate at N+1, busy N+1..N+6, resume at N+6.
    k = cyc;
    exp_inv.push_back(k + 1);
    pushBranch(k + 6, 32'h0000_0200, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0200);
    for (int i = 0; i < 6; i++) begin
      checkOutput("fencei_busy_high", {31'b0, bus.busy_o}, 32'd1);
      idle(1);
    end
    checkOutput("fencei_busy_released", {31'b0, bus.busy_o}, 32'd0);
    idle(2);

    // exec1 during WAIT retargets the resume (PC and privilege); 0x200 never appears.
    k = cyc;
    exp_inv.push_back(k + 1);
    pushBranch(k + 6, 32'h0000_0300, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0200);
    idle(1);
    bus.cur_priv_i = 2'd0;
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0300, 0, 0);
    bus.cur_priv_i = 2'd1;
    idle(6);

    // Reset during WAIT kills the sequence with no trailing pulse.
    k = cyc;
    exp_inv.push_back(k + 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500);
    idle(1);
    rst = 1'b1;
    idle(1);
    checkOutput("midreset_busy", {31'b0, bus.busy_o}, 32'd0);
    checkOutput("midreset_request", {31'b0, bus.branch_request_o}, 32'd0);
    checkOutput("midreset_invalidate", {31'b0, bus.fetch_invalidate_o}, 32'd0);
    checkOutput("midreset_flush_pipe", {31'b0, bus.flush_pipe_o}, 32'd0);
    checkOutput("midreset_branch_pc", bus.branch_pc_o, 32'd0);
    rst = 1'b0;
    idle(10);
    checkOutput("postreset_stat_redirect", bus.stat_redirect_o, 32'd0);

    // Three redirects plus one FENCE.I for the counters.
    k = cyc;
    pushBranch(k + 1, 32'h0000_4000, 2'd1);
    applyStimulus(0, 0, 0, 1, 32'h0000_4000, 0, 0, 0, 0);
    k = cyc;
    pushBranch(k + 1, 32'h0000_5000, 2'd0);
    applyStimulus(1, 32'h0000_5000, 2'd0, 0, 0, 0, 0, 0, 0);
    k = cyc;
    pushBranch(k + 1, 32'h0000_6000, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_6000, 0, 0);
    k = cyc;
    exp_inv.push_back(k + 1);
    pushBranch(k + 6, 32'h0000_7004, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_7004);
    idle(8);
`ifdef FETCH_REDIRECT_STATS_EN
    checkOutput("stat_redirect", bus.stat_redirect_o, 32'd4);
    checkOutput("stat_fencei", bus.stat_fencei_o, 32'd1);
`else
    checkOutput("stat_redirect_tied", bus.stat_redirect_o, 32'd0);
    checkOutput("stat_fencei_tied", bus.stat_fencei_o, 32'd0);
`endif

    idle(4);
    checkOutput("branch_queue_drained", exp_br.size(), 32'd0);
    checkOutput("invalidate_queue_drained", exp_inv.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
